// File: rtl/traffic_light_actuated.sv
// Two-road actuated intersection controller: Moore FSM with minimum greens that
// rest until the cross road calls, yellow and all-red clearance, and a flashing-yellow mode.
module traffic_light_actuated #(
    parameter int CNT_W      = 8,
    parameter int GREEN_A    = 8,
    parameter int GREEN_B    = 10,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             flash_en,
    output logic [2:0]       lightA,
    output logic [2:0]       lightB,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       state,
    output logic             pend_a,
    output logic             pend_b
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (GREEN_A < 1 || GREEN_A > CNT_MAX || GREEN_B < 1 || GREEN_B > CNT_MAX ||
        YELLOW < 1 || YELLOW > CNT_MAX || ALL_RED < 1 || ALL_RED > CNT_MAX ||
        FLASH_HALF < 1 || FLASH_HALF > CNT_MAX) begin : g_bad_duration
        $error("traffic_light_actuated: phase durations must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] T_GA  = CNT_W'(GREEN_A);
    localparam logic [CNT_W-1:0] T_GB  = CNT_W'(GREEN_B);
    localparam logic [CNT_W-1:0] T_Y   = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALL_RED);
    localparam logic [CNT_W-1:0] T_FH  = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        AG    = 3'd0,
        AY    = 3'd1,
        AR1   = 3'd2,
        BG    = 3'd3,
        BY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, DARK = 3'b000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             blink_q, blink_d;
    logic             pend_a_q, pend_a_d;
    logic             pend_b_q, pend_b_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= AG;
            count_q  <= ONE;
            blink_q  <= 1'b0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            blink_q  <= blink_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AG:      if ((count_q >= T_GA && pend_b_q) || flash_en) state_d = AY;
            AY:      if (count_q == T_Y) state_d = AR1;
            AR1:     if (count_q == T_AR) state_d = flash_en ? FLASH : BG;
            BG:      if ((count_q >= T_GB && pend_a_q) || flash_en) state_d = BY;
            BY:      if (count_q == T_Y) state_d = AR2;
            AR2:     if (count_q == T_AR) state_d = flash_en ? FLASH : AG;
            FLASH:   if (!flash_en && count_q == T_FH) state_d = AR2;
            default: state_d = AG;
        endcase

        // Greens rest at their minimum; flash wraps; other phases always leave on ==.
        count_d = count_q + ONE;
        if (state_d != state_q) begin
            count_d = ONE;
        end else begin
            case (state_q)
                AG:      if (count_q >= T_GA) count_d = T_GA;
                BG:      if (count_q >= T_GB) count_d = T_GB;
                FLASH:   if (count_q == T_FH) count_d = ONE;
                default: count_d = count_q + ONE;
            endcase
        end

        blink_d = 1'b0;
        if (state_d == FLASH) begin
            if (state_q != FLASH)      blink_d = 1'b1;
            else if (count_q == T_FH)  blink_d = ~blink_q;
            else                       blink_d = blink_q;
        end

        // Entering (or resting in) a road's green clears its latch, overriding a request.
        pend_a_d = pend_a_q;
        if (state_d == AG)                    pend_a_d = 1'b0;
        else if (req_a && state_q != AG)      pend_a_d = 1'b1;

        pend_b_d = pend_b_q;
        if (state_d == BG)                    pend_b_d = 1'b0;
        else if (req_b && state_q != BG)      pend_b_d = 1'b1;
    end

    always_comb begin
        lightA = RED;
        lightB = RED;
        case (state_q)
            AG:      lightA = GRN;
            AY:      lightA = YEL;
            BG:      lightB = GRN;
            BY:      lightB = YEL;
            FLASH: begin
                lightA = blink_q ? YEL : DARK;
                lightB = blink_q ? YEL : DARK;
            end
            default: begin
                lightA = RED;
                lightB = RED;
            end
        endcase
    end

    assign count  = count_q;
    assign state  = state_q;
    assign pend_a = pend_a_q;
    assign pend_b = pend_b_q;

endmodule

// File: tb/tb_traffic_light_actuated.sv
// Directed bench for traffic_light_actuated: resting green, actuated service,
// full-cycle timing, flashing mode entry/exit and asynchronous reset.
module tb_traffic_light_actuated;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] lightA, lightB;
    logic [7:0] count;
    logic [2:0] state;
    logic       pend_a, pend_b;

    int checks = 0;
    int passed = 0;

    localparam logic [2:0] S_AG = 3'd0, S_AY = 3'd1, S_AR1 = 3'd2, S_BG = 3'd3,
                           S_BY = 3'd4, S_AR2 = 3'd5, S_FLASH = 3'd6;

    traffic_light_actuated dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .flash_en (flash_en),
        .lightA   (lightA),
        .lightB   (lightB),
        .count    (count),
        .state    (state),
        .pend_a   (pend_a),
        .pend_b   (pend_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        else
            passed++;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expects to be at count=1 of the phase; leaves at count=1 of the next phase.
    task automatic phase(input string tag, input logic [2:0] st, input int len,
                         input logic [2:0] la, input logic [2:0] lb);
        check({tag, "_entry_state"}, state, st);
        check({tag, "_entry_count"}, count, 1);
        check({tag, "_lightA"}, lightA, la);
        check({tag, "_lightB"}, lightB, lb);
        tick(len - 1);
        check({tag, "_last_state"}, state, st);
        check({tag, "_last_count"}, count, len);
        tick(1);
    endtask

    initial begin
        // Reset values
        tick(1);
        check("rst_state", state, S_AG);
        check("rst_count", count, 1);
        check("rst_lightA", lightA, 3'b001);
        check("rst_lightB", lightB, 3'b100);
        check("rst_pend_a", pend_a, 0);
        check("rst_pend_b", pend_b, 0);
        rst_n = 1'b1;

        // Rest in AG with no demand, count saturates at GREEN_A
        tick(50);
        check("rest_state", state, S_AG);
        check("rest_count", count, 8);
        check("rest_lightA", lightA, 3'b001);
        check("rest_lightB", lightB, 3'b100);

        // Fresh start, req_b pulse at count=3
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("pulse_at_count", count, 3);
        req_b = 1'b1;
        tick(1);
        req_b = 1'b0;
        check("pend_b_set", pend_b, 1);
        tick(4);
        check("ag_min_state", state, S_AG);
        check("ag_min_count", count, 8);
        tick(1);
        phase("svc_AY", S_AY, 3, 3'b010, 3'b100);
        phase("svc_AR1", S_AR1, 2, 3'b100, 3'b100);
        check("svc_BG_state", state, S_BG);
        check("svc_BG_lightB", lightB, 3'b001);
        check("svc_BG_lightA", lightA, 3'b100);
        check("svc_pend_b_clr", pend_b, 0);
        check("svc_pend_a", pend_a, 0);

        // Both roads calling continuously: exact cycle lengths
        req_a = 1'b1;
        req_b = 1'b1;
        tick(9);
        check("cyc_BG_count", count, 10);
        check("cyc_pend_a", pend_a, 1);
        tick(1);
        for (int i = 0; i < 2; i++) begin
            phase("cyc_BY", S_BY, 3, 3'b100, 3'b010);
            phase("cyc_AR2", S_AR2, 2, 3'b100, 3'b100);
            check("cyc_AG_pend_a", pend_a, 0);
            phase("cyc_AG", S_AG, 8, 3'b001, 3'b100);
            phase("cyc_AY", S_AY, 3, 3'b010, 3'b100);
            phase("cyc_AR1", S_AR1, 2, 3'b100, 3'b100);
            check("cyc_BG_pend_b", pend_b, 0);
            phase("cyc_BG", S_BG, 10, 3'b100, 3'b001);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        phase("drain_BY", S_BY, 3, 3'b100, 3'b010);
        phase("drain_AR2", S_AR2, 2, 3'b100, 3'b100);
        check("drain_AG_state", state, S_AG);
        check("drain_pend_a", pend_a, 0);
        check("drain_pend_b", pend_b, 0);

        // Flash request cuts AG short at count=2
        tick(1);
        check("fl_pre_count", count, 2);
        flash_en = 1'b1;
        tick(1);
        phase("fl_AY", S_AY, 3, 3'b010, 3'b100);
        phase("fl_AR1", S_AR1, 2, 3'b100, 3'b100);
        phase("fl_on1", S_FLASH, 4, 3'b010, 3'b010);
        phase("fl_off", S_FLASH, 4, 3'b000, 3'b000);
        check("fl_on2_state", state, S_FLASH);
        check("fl_on2_count", count, 1);
        check("fl_on2_lightA", lightA, 3'b010);

        // Drop flash mid half-period: held to count=4, then AR2, then AG
        tick(1);
        flash_en = 1'b0;
        tick(1);
        check("fx_hold_state", state, S_FLASH);
        check("fx_hold_count", count, 3);
        tick(1);
        check("fx_end_count", count, 4);
        check("fx_end_lightB", lightB, 3'b010);
        tick(1);
        phase("fx_AR2", S_AR2, 2, 3'b100, 3'b100);
        check("fx_AG_state", state, S_AG);
        check("fx_AG_lightA", lightA, 3'b001);
        check("fx_AG_lightB", lightB, 3'b100);

        // Drive to BY count=2 with a pending A and B, then async reset
        req_b = 1'b1;
        tick(1);
        req_b = 1'b0;
        tick(6);
        check("rb_AG_count", count, 8);
        tick(1);
        phase("rb_AY", S_AY, 3, 3'b010, 3'b100);
        phase("rb_AR1", S_AR1, 2, 3'b100, 3'b100);
        req_a = 1'b1;
        tick(1);
        req_a = 1'b0;
        check("rb_pend_a", pend_a, 1);
        tick(8);
        check("rb_BG_count", count, 10);
        tick(1);
        check("rb_BY_state", state, S_BY);
        req_b = 1'b1;
        tick(1);
        req_b = 1'b0;
        check("rb_BY_count", count, 2);
        check("rb_pend_b", pend_b, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", state, S_AG);
        check("arst_count", count, 1);
        check("arst_lightA", lightA, 3'b001);
        check("arst_lightB", lightB, 3'b100);
        check("arst_pend_a", pend_a, 0);
        check("arst_pend_b", pend_b, 0);
        tick(2);
        check("arst_hold_state", state, S_AG);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
